decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Purpose: in-order decode for a 16-bit machine. Latches one instruction from
// fetch and reads both source registers through the combinational register
// file ports. It stalls while a needed source is busy, then presents the
// operands to execute. On the issue handshake it claims the destination
// register.
//
// Optional feature: define DECODE_FORWARD_EN to bypass a busy source from the
// execute write-back bus (storeNow/destReg/destVal) in the same cycle.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   instr, instrValid          instruction offered by fetch
//   instrReady                 decode accepts instr (IDLE only)
//   srcReg1, srcReg2           register file read addresses (IR rs1/rs2)
//   nextDestReg, destClaim     destination to claim, one-cycle claim pulse
//   srcRegVal1, srcRegVal2     register file read data
//   inuse1, inuse2             busy flags for srcReg1/srcReg2
//   storeNow, destReg, destVal snooped execute write-back
//   exValid, exReady           handshake to execute
//   exOpcode, exOpA, exOpB     issued opcode and operands
//   exDest                     issued destination register
//   halted                     HALT retired; decode frozen until reset
// ----------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instrValid,
    output logic        instrReady,
    output logic [3:0]  srcReg1,
    output logic [3:0]  srcReg2,
    output logic [3:0]  nextDestReg,
    output logic        destClaim,
    input  logic [15:0] srcRegVal1,
    input  logic [15:0] srcRegVal2,
    input  logic        inuse1,
    input  logic        inuse2,
    input  logic        storeNow,
    input  logic [3:0]  destReg,
    input  logic [15:0] destVal,
    output logic        exValid,
    input  logic        exReady,
    output logic [3:0]  exOpcode,
    output logic [15:0] exOpA,
    output logic [15:0] exOpB,
    output logic [3:0]  exDest,
    output logic        halted
);

    localparam int unsigned W_DATA = 16;
    localparam int unsigned W_REG  = 4;
    localparam int unsigned W_OP   = 4;

    localparam logic [W_OP-1:0] OP_ALU_MAX = 4'hB;
    localparam logic [W_OP-1:0] OP_LOADI   = 4'hC;
    localparam logic [W_OP-1:0] OP_CMP     = 4'hD;
    localparam logic [W_OP-1:0] OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_STALL,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W_DATA-1:0]   r_ir;
    logic                r_instr_ready;
    logic                r_ex_valid;
    logic                r_halted;
    logic [W_OP-1:0]     r_ex_opcode;
    logic [W_DATA-1:0]   r_ex_op_a;
    logic [W_DATA-1:0]   r_ex_op_b;
    logic [W_REG-1:0]    r_ex_dest;

    logic [W_OP-1:0]     w_op;
    logic [W_REG-1:0]    w_rd;
    logic [W_REG-1:0]    w_rs1;
    logic [W_REG-1:0]    w_rs2;
    logic                w_reads1;
    logic                w_reads2;
    logic                w_writes;
    logic                w_fwd1;
    logic                w_fwd2;
    logic                w_hazard;
    logic [W_DATA-1:0]   w_op_a;
    logic [W_DATA-1:0]   w_op_b;
    logic                w_claim;
    logic                w_latch_ops;

    // Instruction fields and opcode class decode
    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_rs1    = r_ir[7:4];
    assign w_rs2    = r_ir[3:0];
    assign w_reads1 = (w_op <= OP_ALU_MAX) || (w_op == OP_CMP);
    assign w_reads2 = w_reads1;
    assign w_writes = (w_op <= OP_LOADI);

    // Write-back bypass match per source
`ifdef DECODE_FORWARD_EN
    assign w_fwd1 = storeNow && (destReg == w_rs1);
    assign w_fwd2 = storeNow && (destReg == w_rs2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
    logic w_unused_snoop;
    assign w_unused_snoop = ^{storeNow, destReg, destVal};
`endif

    // Source hazard: a read source is busy and not being bypassed
    assign w_hazard = (w_reads1 && inuse1 && !w_fwd1) ||
                      (w_reads2 && inuse2 && !w_fwd2);

    // Operand selection; LOADI carries its immediate in the rs1/rs2 fields
    always_comb begin
        w_op_a = w_fwd1 ? destVal : srcRegVal1;
        w_op_b = w_fwd2 ? destVal : srcRegVal2;
        if (w_op == OP_LOADI) begin
            w_op_a = {8'h00, r_ir[7:0]};
            w_op_b = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake decode
    always_comb begin
        w_next      = r_state;
        w_claim     = 1'b0;
        w_latch_ops = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instrValid) w_next = S_READ;
            end
            S_READ, S_STALL: begin
                // HALT reads no sources, so it can never reach STALL
                if (w_op == OP_HALT) begin
                    w_next = S_HALTED;
                end else if (w_hazard) begin
                    w_next = S_STALL;
                end else begin
                    w_next      = S_ISSUE;
                    w_latch_ops = 1'b1;
                end
            end
            S_ISSUE: begin
                if (exReady) begin
                    w_claim = w_writes;
                    w_next  = S_IDLE;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir          <= '0;
            r_instr_ready <= 1'b1;
            r_ex_valid    <= 1'b0;
            r_halted      <= 1'b0;
            r_ex_opcode   <= '0;
            r_ex_op_a     <= '0;
            r_ex_op_b     <= '0;
            r_ex_dest     <= '0;
        end else begin
            r_instr_ready <= (w_next == S_IDLE);
            r_ex_valid    <= (w_next == S_ISSUE);
            r_halted      <= (w_next == S_HALTED);
            if (r_state == S_IDLE && instrValid) r_ir <= instr;
            if (w_latch_ops) begin
                r_ex_opcode <= w_op;
                r_ex_op_a   <= w_op_a;
                r_ex_op_b   <= w_op_b;
                r_ex_dest   <= w_rd;
            end
        end
    end

    assign instrReady  = r_instr_ready;
    assign srcReg1     = w_rs1;
    assign srcReg2     = w_rs2;
    assign nextDestReg = w_rd;
    // The claim must coincide with the handshake, while nextDestReg still shows rd
    assign destClaim   = w_claim && !rst;
    assign exValid     = r_ex_valid;
    assign exOpcode    = r_ex_opcode;
    assign exOpA       = r_ex_op_a;
    assign exOpB       = r_ex_op_b;
    assign exDest      = r_ex_dest;
    assign halted      = r_halted;

endmodule
